// File: rtl/norm_pkg.sv
// Shared types and helpers for the sequential normalizer.
// Holds the FSM state encoding and the stage-count helper.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One binary-search stage per bit of the shift amount.
  function automatic int stage_count(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/normalize_step.sv
// One combinational binary-search stage.
// Shifts left by 'shift' when the top bits carry no information.
module normalize_step #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic [WIDTH-1:0] data,
  input  logic             arith,
  input  logic [SW-1:0]    shift,
  output logic [WIDTH-1:0] data_next,
  output logic             hit
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] top_mask;
  logic [WIDTH-1:0] sign_mask;
  logic [WIDTH-1:0] sign_diff;
  logic [SW:0]      shift_p1;

  // Signed mode needs s+1 matching bits: the bit just below the shifted-out
  // field becomes the new MSB and must still equal the sign.
  assign shift_p1  = {1'b0, shift} + 1'b1;
  assign top_mask  = ~(ONES >> shift);
  assign sign_mask = ~(ONES >> shift_p1);
  assign sign_diff = data ^ {WIDTH{data[WIDTH-1]}};

  assign hit       = arith ? ((sign_diff & sign_mask) == '0)
                           : ((data & top_mask) == '0);
  assign data_next = hit ? (data << shift) : data;

endmodule

// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: counts leading zeros or redundant sign bits with a
// binary search, one stage per cycle, and left-shifts the operand by that count.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// RUN   | one search stage per cycle, k from L-1 down to 0
// DONE  | result held, out_valid=1, waiting for out_ready
module seq_normalizer
  import norm_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int L    = stage_count(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [L:0]       shift_amt,
  output logic             zero
);

  state_t           state;
  state_t           state_next;
  logic [L-1:0]     k;
  logic [L-1:0]     count;
  logic [L-1:0]     count_next;
  logic [L-1:0]     stage_s;
  logic [WIDTH-1:0] work;
  logic             work_arith;
  logic [WIDTH-1:0] step_data;
  logic             step_hit;

  assign stage_s    = {{(L-1){1'b0}}, 1'b1} << k;
  assign count_next = step_hit ? (count + stage_s) : count;

  normalize_step #(
    .WIDTH (WIDTH),
    .SW    (L)
  ) u_step (
    .data      (work),
    .arith     (work_arith),
    .shift     (stage_s),
    .data_next (step_data),
    .hit       (step_hit)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (k == '0)   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work       <= '0;
      work_arith <= 1'b0;
      count      <= '0;
      k          <= '0;
      data_out   <= '0;
      shift_amt  <= '0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work       <= data_in;
            work_arith <= arith;
            count      <= '0;
            k          <= L'(L - 1);
          end
        end
        RUN: begin
          work  <= step_data;
          count <= count_next;
          k     <= k - 1'b1;
          if (k == '0) begin
            data_out <= step_data;
            zero     <= (step_data == '0);
            // Only an all-zero unsigned operand reports the full width.
            shift_amt <= (!work_arith && step_data == '0) ? (L+1)'(WIDTH)
                                                          : {1'b0, count_next};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed bench for seq_normalizer (WIDTH=32) with a scoreboard queue and a
// bit-serial reference model independent of the binary search.
module tb_seq_normalizer;

  localparam int WIDTH = 32;
  localparam int L     = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             arith;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [L:0]       shift_amt;
  logic             zero;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [L:0]       amt;
    logic             z;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs    = 0;

  seq_normalizer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .shift_amt (shift_amt),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: walk down from the MSB one bit at a time.
  function automatic exp_t model(input logic [WIDTH-1:0] d, input logic a);
    exp_t e;
    int   n;
    n = 0;
    if (!a) begin
      while (n < WIDTH && d[WIDTH-1-n] == 1'b0) n++;
    end else begin
      while (n < WIDTH-1 && d[WIDTH-2-n] == d[WIDTH-1]) n++;
    end
    e.d   = (n >= WIDTH) ? '0 : (d << n);
    e.amt = (L+1)'(n);
    e.z   = (d == '0);
    return e;
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] d, input logic a,
                       input bit early, input int hold);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    data_in   = d;
    arith     = a;
    out_ready = early;
    sb.push_back(model(d, a));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = ~d;
    arith    = ~a;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    e = sb.pop_front();
    check("result_seen", 64'(seen), 64'd1);
    if (!seen) return;
    check("latency", 64'(lat), 64'(L));
    check("data_out", 64'(data_out), 64'(e.d));
    check("shift_amt", 64'(shift_amt), 64'(e.amt));
    check("zero", 64'(zero), 64'(e.z));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
      data_in  = 32'h0000_1234;
      arith    = 1'b0;
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_data", 64'(data_out), 64'(e.d));
      check("hold_amt", 64'(shift_amt), 64'(e.amt));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff_valid", 64'(out_valid), 64'd0);
    check("handoff_in_ready", 64'(in_ready), 64'd1);
    check("kept_data", 64'(data_out), 64'(e.d));
    check("kept_amt", 64'(shift_amt), 64'(e.amt));
    out_ready = 1'b0;
  endtask

  initial begin
    bit spurious;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    arith     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_amt", 64'(shift_amt), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(32'h0000_00F0, 1'b0, 1'b0, 0);
    do_op(32'h8000_0000, 1'b0, 1'b0, 0);
    do_op(32'h0000_0000, 1'b0, 1'b0, 0);
    do_op(32'hFFFF_FFF0, 1'b1, 1'b0, 0);
    do_op(32'h0000_0001, 1'b1, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 1'b1, 1'b1, 0);
    do_op(32'h0000_0000, 1'b1, 1'b1, 0);
    do_op(32'h0001_2345, 1'b0, 1'b0, 3);
    do_op(32'h7FFF_FFFF, 1'b1, 1'b0, 0);
    do_op(32'h4000_0000, 1'b1, 1'b1, 0);
    do_op(32'h0000_0001, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      do_op($urandom() >> $urandom_range(31, 0), 1'($urandom_range(1, 0)), 1'b0, 0);

    // Abort an operand during its second RUN cycle.
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 32'h0000_0F00;
    arith    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_data", 64'(data_out), 64'd0);
    check("abort_amt", 64'(shift_amt), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious = 1'b1;
    end
    check("no_result_after_abort", 64'(spurious), 64'd0);
    do_op(32'h00F0_0000, 1'b0, 1'b0, 0);
    do_op(32'hFFF0_0000, 1'b1, 1'b0, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
